// File: rtl/aes_pkg.sv
// Shared types and constants for the AES key-schedule engine.
//   aes_mode_e : key-size selector (AES-128/192/256, 3 = illegal)
//   ks_state_e : expansion FSM state, also exported for debug
//   word_t     : one 32-bit schedule word
//   rcon_of, nk_of, nr_of, total_of : per-mode constants
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        AES128  = 2'd0,
        AES192  = 2'd1,
        AES256  = 2'd2,
        ILLEGAL = 2'd3
    } aes_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_e;

    // Round-constant bytes; entry 0 is unused because rcon indices start at 1.
    localparam logic [7:0] RCON_TBL [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic word_t rcon_of(input logic [3:0] j);
        logic [7:0] rc;
        rc = 8'h00;
        if (j <= 4'd10) begin
            rc = RCON_TBL[j];
        end
        return {rc, 24'h000000};
    endfunction

    // Key length in words.
    function automatic logic [3:0] nk_of(input aes_mode_e m);
        case (m)
            AES192:  return 4'd6;
            AES256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr_of(input aes_mode_e m);
        case (m)
            AES192:  return 4'd12;
            AES256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    // Words in the full schedule, 4*(Nr+1).
    function automatic logic [5:0] total_of(input aes_mode_e m);
        case (m)
            AES192:  return 6'd52;
            AES256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: the AES S-box applied to each byte of a 32-bit word.
//   word_i : input word
//   word_o : byte-wise substituted word
module sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8 * (255 - int'(b)) +: 8];
    endfunction

    always_comb begin
        word_o = '0;
        for (int k = 0; k < 4; k++) begin
            word_o[8*k +: 8] = sbox(word_i[8*k +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule, one expanded word per clock.
// The key is expanded once per load into an internal word array; any round
// key can then be read combinationally by the execute stage.
//   clk, rst     : clock, synchronous active-high reset
//   start, mode  : expansion request and key size (3 = illegal)
//   key_in       : cipher key, w[0] in the top 32 bits
//   busy, done   : expansion in progress / one-cycle completion pulse
//   err          : one-cycle pulse when start is accepted with mode 3
//   keys_ready   : array holds a complete schedule for the latched mode
//   rk_idx       : round-key index 0..Nr
//   rk_out       : {w[4i], w[4i+1], w[4i+2], w[4i+3]}
//   rk_valid     : keys_ready and rk_idx within the latched mode's range
//   state_dbg    : current FSM state
//
// Handshake: start is a level request sampled only in IDLE. An accepted
// legal start raises busy on the next edge and drops keys_ready until the
// cycle in which done pulses; start seen while busy is ignored, not queued.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4,
    parameter int NK_MAX  = 8,
    parameter int NR_MAX  = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [NK_MAX*regSize-1:0]  key_in,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       keys_ready,
    input  logic [3:0]                 rk_idx,
    output logic [vecSize*regSize-1:0] rk_out,
    output logic                       rk_valid,
    output ks_state_e                  state_dbg
);

    localparam int DEPTH = vecSize * (NR_MAX + 1);

    ks_state_e  state_q;
    logic       busy_q, done_q, err_q, keys_ready_q;
    aes_mode_e  mode_q;
    logic [5:0] i_q, total_q, nk_q;
    // pos_q tracks i%Nk and rcon_j_q tracks i/Nk, so no divider is needed.
    logic [2:0] pos_q, last_pos_q;
    logic [3:0] rcon_j_q;

    word_t w_q [DEPTH];

    aes_mode_e mode_in;
    logic      load_en, expand_en;
    word_t     prev_w, rot_w, sub_in, sub_out, t_w, new_w;

    assign mode_in   = aes_mode_e'(mode);
    assign load_en   = (state_q == ST_IDLE) && start && (mode_in != ILLEGAL);
    assign expand_en = (state_q == ST_EXPAND);

    // One S-box bank serves both the RotWord+Rcon step and the AES-256
    // SubWord-only step; the two never occur in the same cycle.
    sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        prev_w = w_q[i_q - 6'd1];
        rot_w  = {prev_w[23:0], prev_w[31:24]};
        sub_in = (pos_q == 3'd0) ? rot_w : prev_w;
        t_w    = prev_w;
        if (pos_q == 3'd0) begin
            t_w = sub_out ^ rcon_of(rcon_j_q);
        end else if (mode_q == AES256 && pos_q == 3'd4) begin
            t_w = sub_out;
        end
        new_w = w_q[i_q - nk_q] ^ t_w;
    end

    // FSM, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            keys_ready_q <= 1'b0;
            mode_q       <= AES128;
            i_q          <= '0;
            total_q      <= '0;
            nk_q         <= '0;
            pos_q        <= '0;
            last_pos_q   <= '0;
            rcon_j_q     <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (mode_in == ILLEGAL) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q       <= mode_in;
                            nk_q         <= {2'b00, nk_of(mode_in)};
                            last_pos_q   <= 3'(nk_of(mode_in) - 4'd1);
                            total_q      <= total_of(mode_in);
                            i_q          <= {2'b00, nk_of(mode_in)};
                            pos_q        <= 3'd0;
                            rcon_j_q     <= 4'd1;
                            keys_ready_q <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    i_q <= i_q + 6'd1;
                    if (pos_q == last_pos_q) begin
                        pos_q    <= 3'd0;
                        rcon_j_q <= rcon_j_q + 4'd1;
                    end else begin
                        pos_q <= pos_q + 3'd1;
                    end
                    if (i_q == total_q - 6'd1) begin
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        keys_ready_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Word array: not reset; its contents only matter once keys_ready is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_en) begin
                for (int k = 0; k < NK_MAX; k++) begin
                    if (4'(k) < nk_of(mode_in)) begin
                        w_q[k] <= key_in[(NK_MAX-1-k)*regSize +: regSize];
                    end
                end
            end else if (expand_en) begin
                w_q[i_q] <= new_w;
            end
        end
    end

    // Combinational read port; out-of-range indices alias round key 0.
    logic [3:0] rd_idx;
    logic [5:0] rd_base;

    always_comb begin
        rd_idx  = (rk_idx > 4'(NR_MAX)) ? 4'd0 : rk_idx;
        rd_base = {rd_idx, 2'b00};
        rk_out  = '0;
        for (int k = 0; k < vecSize; k++) begin
            rk_out[(vecSize-1-k)*regSize +: regSize] = w_q[rd_base + 6'(k)];
        end
    end

    assign rk_valid   = keys_ready_q && (rk_idx <= nr_of(mode_q));
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign keys_ready = keys_ready_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;
    import aes_pkg::*;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         busy, done, err, keys_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
    ks_state_e    state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    aes_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .keys_ready (keys_ready),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid),
        .state_dbg  (state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver: issues start, returns the cycle (T+n) in which done is seen,
    // or -1 if it never arrives within the budget. If restart_at >= 0,
    // start is pulsed again that many cycles into the run.
    task automatic run_expand(input logic [1:0] m, input logic [255:0] k,
                              input int restart_at, output int done_cyc,
                              output logic busy_early, output logic kr_early);
        int n;
        @(posedge clk); #1;
        mode = m; key_in = k; start = 1'b1;
        @(posedge clk); #1;           // edge T samples start
        start = 1'b0;
        busy_early = busy;
        kr_early   = keys_ready;
        n = 0;
        done_cyc = -1;
        while (n < 200 && done_cyc < 0) begin
            if (done) begin
                done_cyc = n + 1;
            end else begin
                start = (n == restart_at);
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'd0; key_in = '0; rk_idx = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
        total_cnt++;
        if (keys_ready !== 1'b0) $display("FAIL reset_keys_ready got=%b exp=0", keys_ready); else pass_cnt++;
        total_cnt++;
        if (rk_valid !== 1'b0) $display("FAIL reset_rk_valid got=%b exp=0", rk_valid); else pass_cnt++;
        total_cnt++;
        if (state_dbg !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_aes128();
        int dc; logic be, ke;
        run_expand(2'd0, K128, -1, dc, be, ke);
        total_cnt++;
        if (be !== 1'b1) $display("FAIL a128_busy_early got=%b exp=1", be); else pass_cnt++;
        total_cnt++;
        if (ke !== 1'b0) $display("FAIL a128_kr_early got=%b exp=0", ke); else pass_cnt++;
        total_cnt++;
        if (dc !== 41) $display("FAIL a128_done_cycle got=%0d exp=41", dc); else pass_cnt++;
        total_cnt++;
        if (keys_ready !== 1'b1) $display("FAIL a128_keys_ready got=%b exp=1", keys_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL a128_done_pulse got=%b exp=0", done); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL a128_busy_after got=%b exp=0", busy); else pass_cnt++;
        rk_idx = 4'd0; #1;
        total_cnt++;
        if (rk_out !== K128[255:128]) $display("FAIL a128_rk0 got=%h exp=%h", rk_out, K128[255:128]); else pass_cnt++;
        rk_idx = 4'd1; #1;
        total_cnt++;
        if (rk_out !== RK128_1) $display("FAIL a128_rk1 got=%h exp=%h", rk_out, RK128_1); else pass_cnt++;
        rk_idx = 4'd10; #1;
        total_cnt++;
        if (rk_out !== RK128_10) $display("FAIL a128_rk10 got=%h exp=%h", rk_out, RK128_10); else pass_cnt++;
        total_cnt++;
        if (rk_valid !== 1'b1) $display("FAIL a128_rk10_valid got=%b exp=1", rk_valid); else pass_cnt++;
        rk_idx = 4'd11; #1;
        total_cnt++;
        if (rk_valid !== 1'b0) $display("FAIL a128_rk11_valid got=%b exp=0", rk_valid); else pass_cnt++;
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        rk_idx = 4'd10; mode = 2'd3; key_in = K256; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL illegal_err got=%b exp=1", err); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL illegal_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++;
        if (keys_ready !== 1'b1) $display("FAIL illegal_keys_ready got=%b exp=1", keys_ready); else pass_cnt++;
        total_cnt++;
        if (rk_out !== RK128_10) $display("FAIL illegal_rk10 got=%h exp=%h", rk_out, RK128_10); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL illegal_err_pulse got=%b exp=0", err); else pass_cnt++;
        total_cnt++;
        if (state_dbg !== ST_IDLE) $display("FAIL illegal_state got=%0d exp=%0d", state_dbg, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_aes192();
        int dc; logic be, ke;
        run_expand(2'd1, K192, -1, dc, be, ke);
        total_cnt++;
        if (dc !== 47) $display("FAIL a192_done_cycle got=%0d exp=47", dc); else pass_cnt++;
        rk_idx = 4'd1; #1;
        total_cnt++;
        if (rk_out[63:32] !== 32'hfe0c91f7) $display("FAIL a192_w6 got=%h exp=fe0c91f7", rk_out[63:32]); else pass_cnt++;
        total_cnt++;
        if (rk_out[127:64] !== 64'h62f8ead2522c6b7b) $display("FAIL a192_w4w5 got=%h exp=62f8ead2522c6b7b", rk_out[127:64]); else pass_cnt++;
        rk_idx = 4'd12; #1;
        total_cnt++;
        if (rk_out[31:0] !== 32'h01002202) $display("FAIL a192_w51 got=%h exp=01002202", rk_out[31:0]); else pass_cnt++;
        total_cnt++;
        if (rk_valid !== 1'b1) $display("FAIL a192_rk12_valid got=%b exp=1", rk_valid); else pass_cnt++;
        rk_idx = 4'd13; #1;
        total_cnt++;
        if (rk_valid !== 1'b0) $display("FAIL a192_rk13_valid got=%b exp=0", rk_valid); else pass_cnt++;
    endtask

    task automatic test_aes256();
        int dc; logic be, ke;
        run_expand(2'd2, K256, -1, dc, be, ke);
        total_cnt++;
        if (dc !== 53) $display("FAIL a256_done_cycle got=%0d exp=53", dc); else pass_cnt++;
        rk_idx = 4'd1; #1;
        total_cnt++;
        if (rk_out !== K256[127:0]) $display("FAIL a256_rk1 got=%h exp=%h", rk_out, K256[127:0]); else pass_cnt++;
        rk_idx = 4'd2; #1;
        total_cnt++;
        if (rk_out[127:96] !== 32'h9ba35411) $display("FAIL a256_w8 got=%h exp=9ba35411", rk_out[127:96]); else pass_cnt++;
        rk_idx = 4'd3; #1;
        total_cnt++;
        if (rk_out[127:96] !== 32'ha8b09c1a) $display("FAIL a256_w12 got=%h exp=a8b09c1a", rk_out[127:96]); else pass_cnt++;
        rk_idx = 4'd14; #1;
        total_cnt++;
        if (rk_out[31:0] !== 32'h706c631e) $display("FAIL a256_w59 got=%h exp=706c631e", rk_out[31:0]); else pass_cnt++;
        total_cnt++;
        if (rk_valid !== 1'b1) $display("FAIL a256_rk14_valid got=%b exp=1", rk_valid); else pass_cnt++;
        rk_idx = 4'd15; #1;
        total_cnt++;
        if (rk_valid !== 1'b0) $display("FAIL a256_rk15_valid got=%b exp=0", rk_valid); else pass_cnt++;
    endtask

    task automatic test_restart_ignored();
        int dc; logic be, ke;
        run_expand(2'd0, K128, 9, dc, be, ke);
        total_cnt++;
        if (ke !== 1'b0) $display("FAIL restart_kr_dropped got=%b exp=0", ke); else pass_cnt++;
        total_cnt++;
        if (dc !== 41) $display("FAIL restart_done_cycle got=%0d exp=41", dc); else pass_cnt++;
        rk_idx = 4'd1; #1;
        total_cnt++;
        if (rk_out !== RK128_1) $display("FAIL restart_rk1 got=%h exp=%h", rk_out, RK128_1); else pass_cnt++;
        rk_idx = 4'd10; #1;
        total_cnt++;
        if (rk_out !== RK128_10) $display("FAIL restart_rk10 got=%h exp=%h", rk_out, RK128_10); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL restart_no_requeue got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dc; logic be, ke;
        @(posedge clk); #1;
        mode = 2'd2; key_in = K256; start = 1'b1;
        @(posedge clk); #1;           // edge T
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before got=%b exp=1", busy); else pass_cnt++;
        rst = 1'b1;                   // sampled at edge T+20
        @(posedge clk); #1;
        rst = 1'b0;
        rk_idx = 4'd0; #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++;
        if (keys_ready !== 1'b0) $display("FAIL midrst_keys_ready got=%b exp=0", keys_ready); else pass_cnt++;
        total_cnt++;
        if (rk_valid !== 1'b0) $display("FAIL midrst_rk_valid got=%b exp=0", rk_valid); else pass_cnt++;
        total_cnt++;
        if (state_dbg !== ST_IDLE) $display("FAIL midrst_state got=%0d exp=%0d", state_dbg, ST_IDLE); else pass_cnt++;
        run_expand(2'd0, K128, -1, dc, be, ke);
        total_cnt++;
        if (dc !== 41) $display("FAIL midrst_a128_done got=%0d exp=41", dc); else pass_cnt++;
        rk_idx = 4'd10; #1;
        total_cnt++;
        if (rk_out !== RK128_10) $display("FAIL midrst_a128_rk10 got=%h exp=%h", rk_out, RK128_10); else pass_cnt++;
        total_cnt++;
        if (rk_valid !== 1'b1) $display("FAIL midrst_a128_valid got=%b exp=1", rk_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_illegal();
        test_aes192();
        test_aes256();
        test_restart_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
